pump_console: RTL
=================

# pump_console

Customer-side console for the gas station controller. It turns raw button presses, coin strobes and flow-meter pulses into the controller's UNLEADED, MONEY, TANKFULL and CARWASH_I inputs. It paces itself off the controller's Moore outputs: READY, FEEDME, DELIVERGAS and CARWASH_O. It also tracks customer credit and dispensed volume, and returns change at the end of each transaction.

## Interface
- PRICE, 100: credit units charged per fill.
- CREDIT_W, 12: width of the credit accumulator.
- TANK_UNITS, 40: flow pulses that make a full tank (1..255).
- DEBOUNCE_CYCLES, 16: stable cycles required by the debouncer.

- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- btn_unleaded  in  1  raw unleaded button, asynchronous
- btn_carwash  in  1  raw carwash button, asynchronous
- coin_valid  in  1  one-cycle coin strobe, synchronous
- coin_value  in  8  coin value in credit units, qualified by coin_valid
- flow_pulse  in  1  one-cycle pulse per dispensed unit, synchronous
- READY, FEEDME, DELIVERGAS, CARWASH_O  in  1 each  controller status
- UNLEADED, MONEY, CARWASH_I  out  1 each  one-cycle request pulses to the controller
- TANKFULL  out  1  level to the controller
- credit  out  CREDIT_W  current credit
- volume  out  8  units dispensed this transaction
- change_valid  out  1  one-cycle pulse; change holds the refund on that cycle
- change  out  CREDIT_W  refund amount

## Operation
- Reset values: all outputs 0; FSM in C_IDLE.
- FSM states and transitions:
  - C_IDLE: on READY=1 and a debounced rising edge of btn_unleaded → pulse UNLEADED → C_PAY. A press while READY=0 is discarded.
  - C_PAY: when FEEDME=1 and credit ≥ PRICE → pulse MONEY, credit −= PRICE → C_PUMP. Credit below PRICE waits indefinitely.
  - C_PUMP: while DELIVERGAS=1, each flow_pulse increments volume. When volume == TANK_UNITS, TANKFULL goes high and further pulses are ignored. When DELIVERGAS falls (tank full or emergency stop at the controller) → TANKFULL=0 → C_WASH.
  - C_WASH: on CARWASH_O=1 and a debounced btn_carwash press → pulse CARWASH_I and change_valid with change=credit; credit←0, volume←0 → C_IDLE.
- Coins are accepted in every state.
  - credit_next = credit + coin − (MONEY ? PRICE : 0), computed in CREDIT_W+1 bits and saturated at 2^CREDIT_W−1.
- A coin arriving in the same cycle as the MONEY deduction is counted: both terms apply in that cycle.
- flow_pulse while DELIVERGAS=0 is ignored.
- Reset mid-transaction clears credit without a refund. The controller is not reset by this block.

## Timing
- Coin sampled at cycle N → credit updated at N+1.
- Button input to pulse: 2-flop synchronizer, then debounce (if enabled), then edge detect. The output pulse is registered.
  - Latency is 3 cycles without debounce and 3+DEBOUNCE_CYCLES cycles with it.
- MONEY fires the cycle after the FEEDME=1 ∧ credit≥PRICE condition is sampled.
- The last counted flow_pulse at cycle N → TANKFULL=1 at N+1. TANKFULL stays high until the cycle after DELIVERGAS=0 is sampled.
- Every request pulse is exactly one cycle wide. The controller samples it on its next rising edge.

## Configuration
- CONSOLE_DEBOUNCE_EN defined:
  - Each button passes through button_debounce.
  - The synchronized level must hold stable for DEBOUNCE_CYCLES cycles before the filtered level changes.
- CONSOLE_DEBOUNCE_EN undefined:
  - Buttons use the 2-flop synchronizer only; no counter logic is generated.

## Structure
- Shared package gas_pkg:
  - controller state encodings (needgastype 2'b00, needmoney 2'b01, delivering 2'b10, wantcarwash 2'b11);
  - console FSM enum (C_IDLE, C_PAY, C_PUMP, C_WASH);
  - default PRICE and TANK_UNITS constants.
- Sub-module button_debounce holds the synchronizer, the stability counter and the rising-edge detect. It is instantiated twice.

## Test plan
- Reset, READY=1, press unleaded 40 cycles → one UNLEADED pulse at the documented latency; a second press in C_PAY → no pulse.
- FEEDME=1, coins 25,25,25,50 → credit 25,50,75,125 → MONEY pulse, credit=25.
- Coin 50 on the exact MONEY cycle with credit=100 → credit=50.
- DELIVERGAS=1, 45 flow pulses with TANK_UNITS=40 → volume=40, TANKFULL high from the cycle after the 40th pulse; DELIVERGAS→0 clears TANKFULL.
- Emergency: DELIVERGAS falls at volume=12 → TANKFULL never asserted, state C_WASH.
- CARWASH_O=1, carwash press with credit=25 → CARWASH_I pulse, change_valid with change=25, credit=0, volume=0. Reset asserted mid-C_PUMP → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/gas_pkg.sv
// gas_pkg: shared types and defaults for the gas station console.
// Holds the controller state encodings, the console FSM enum and the
// default pricing / tank constants used by pump_console.
package gas_pkg;

    // Controller (gas station FSM) state encodings.
    typedef enum logic [1:0] {
        needgastype = 2'b00,
        needmoney   = 2'b01,
        delivering  = 2'b10,
        wantcarwash = 2'b11
    } ctrl_state_e;

    // Console FSM states.
    typedef enum logic [1:0] {
        C_IDLE = 2'b00,
        C_PAY  = 2'b01,
        C_PUMP = 2'b10,
        C_WASH = 2'b11
    } console_state_e;

    localparam int unsigned DEFAULT_PRICE      = 100;
    localparam int unsigned DEFAULT_TANK_UNITS = 40;
    localparam int unsigned COIN_W             = 8;
    localparam int unsigned VOLUME_W           = 8;

endpackage : gas_pkg

// File: rtl/button_debounce.sv
// button_debounce: conditions one raw asynchronous button.
// 2-flop synchronizer, optional stability filter, rising-edge detect.
// Optional feature macro: CONSOLE_DEBOUNCE_EN (adds the stability counter).
// Ports:
//   clock, reset_n : clock, async active-low reset
//   btn_i          : raw button level (asynchronous)
//   rise_c_o       : combinational one-cycle pulse on a (filtered) rising edge
module button_debounce
`ifdef CONSOLE_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic clock,
    input  logic reset_n,
    input  logic btn_i,
    output logic rise_c_o
);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic prev_q;

    // Two-flop synchronizer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef CONSOLE_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;

    // Filtered level follows the synchronized level only after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else if (sync2_q == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q  <= '0;
            filt_q <= sync2_q;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    // Edge detect; the consumer registers the pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise_c_o = level & ~prev_q;

endmodule : button_debounce

// File: rtl/pump_console.sv
// pump_console: customer console in front of the gas station controller.
// Converts button presses, coins and flow pulses into UNLEADED / MONEY /
// TANKFULL / CARWASH_I, tracks credit and volume, refunds change.
// Optional feature macro: CONSOLE_DEBOUNCE_EN (button stability filter).
// Ports:
//   clock, reset_n                   : clock, async active-low reset
//   btn_unleaded, btn_carwash        : raw async buttons
//   coin_valid, coin_value           : coin strobe and value
//   flow_pulse                       : one pulse per dispensed unit
//   READY, FEEDME, DELIVERGAS, CARWASH_O : controller status
//   UNLEADED, MONEY, CARWASH_I       : one-cycle requests to controller
//   TANKFULL                         : level to controller
//   credit, volume                   : running credit / dispensed units
//   change_valid, change             : refund strobe and amount
module pump_console
    import gas_pkg::*;
#(
    parameter int unsigned PRICE      = DEFAULT_PRICE,
    parameter int unsigned CREDIT_W   = 12,
    parameter int unsigned TANK_UNITS = DEFAULT_TANK_UNITS
`ifdef CONSOLE_DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                btn_unleaded,
    input  logic                btn_carwash,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_value,
    input  logic                flow_pulse,
    input  logic                READY,
    input  logic                FEEDME,
    input  logic                DELIVERGAS,
    input  logic                CARWASH_O,
    output logic                UNLEADED,
    output logic                MONEY,
    output logic                CARWASH_I,
    output logic                TANKFULL,
    output logic [CREDIT_W-1:0] credit,
    output logic [VOLUME_W-1:0] volume,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change
);

    localparam int unsigned SUM_W = CREDIT_W + 1;
    localparam logic [VOLUME_W-1:0] TANK_LIM = VOLUME_W'(TANK_UNITS);

    logic unl_rise_c;
    logic cw_rise_c;

    button_debounce
`ifdef CONSOLE_DEBOUNCE_EN
        #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
        u_unl_btn (
            .clock    (clock),
            .reset_n  (reset_n),
            .btn_i    (btn_unleaded),
            .rise_c_o (unl_rise_c)
        );

    button_debounce
`ifdef CONSOLE_DEBOUNCE_EN
        #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
        u_cw_btn (
            .clock    (clock),
            .reset_n  (reset_n),
            .btn_i    (btn_carwash),
            .rise_c_o (cw_rise_c)
        );

    console_state_e      state_q, state_d;
    logic                unleaded_q, unleaded_d;
    logic                money_q, money_d;
    logic                carwash_q, carwash_d;
    logic                tankfull_q, tankfull_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [VOLUME_W-1:0] volume_q, volume_d;
    logic                change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                dg_prev_q;

    logic [SUM_W-1:0]    credit_sum;
    logic [CREDIT_W-1:0] credit_sat;
    logic [VOLUME_W-1:0] vol_inc;

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= C_IDLE;
            unleaded_q     <= 1'b0;
            money_q        <= 1'b0;
            carwash_q      <= 1'b0;
            tankfull_q     <= 1'b0;
            credit_q       <= '0;
            volume_q       <= '0;
            change_valid_q <= 1'b0;
            change_q       <= '0;
            dg_prev_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            unleaded_q     <= unleaded_d;
            money_q        <= money_d;
            carwash_q      <= carwash_d;
            tankfull_q     <= tankfull_d;
            credit_q       <= credit_d;
            volume_q       <= volume_d;
            change_valid_q <= change_valid_d;
            change_q       <= change_d;
            dg_prev_q      <= DELIVERGAS;
        end
    end

    // Next-state, request pulses, credit and volume bookkeeping.
    always_comb begin
        state_d        = state_q;
        unleaded_d     = 1'b0;
        money_d        = 1'b0;
        carwash_d      = 1'b0;
        tankfull_d     = tankfull_q;
        volume_d       = volume_q;
        change_valid_d = 1'b0;
        change_d       = '0;

        // Deduction is keyed off the registered MONEY pulse, so a coin in
        // the MONEY cycle lands in the same update. MONEY only fires with
        // credit >= PRICE, so the top bit can only mean overflow.
        credit_sum = {1'b0, credit_q}
                   + (coin_valid ? SUM_W'(coin_value) : SUM_W'(0))
                   - (money_q ? SUM_W'(PRICE) : SUM_W'(0));
        credit_sat = credit_sum[CREDIT_W] ? '1 : credit_sum[CREDIT_W-1:0];
        credit_d   = credit_sat;
        vol_inc    = volume_q + VOLUME_W'(1);

        case (state_q)
            C_IDLE: begin
                if (READY && unl_rise_c) begin
                    unleaded_d = 1'b1;
                    state_d    = C_PAY;
                end
            end
            C_PAY: begin
                if (FEEDME && (credit_q >= CREDIT_W'(PRICE))) begin
                    money_d = 1'b1;
                    state_d = C_PUMP;
                end
            end
            C_PUMP: begin
                // Leave only on a falling DELIVERGAS, not before it has risen.
                if (dg_prev_q && !DELIVERGAS) begin
                    tankfull_d = 1'b0;
                    state_d    = C_WASH;
                end else if (DELIVERGAS && flow_pulse && (volume_q < TANK_LIM)) begin
                    volume_d = vol_inc;
                    if (vol_inc == TANK_LIM) begin
                        tankfull_d = 1'b1;
                    end
                end
            end
            C_WASH: begin
                // Refund includes any coin arriving this same cycle.
                if (CARWASH_O && cw_rise_c) begin
                    carwash_d      = 1'b1;
                    change_valid_d = 1'b1;
                    change_d       = credit_sat;
                    credit_d       = '0;
                    volume_d       = '0;
                    state_d        = C_IDLE;
                end
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    assign UNLEADED     = unleaded_q;
    assign MONEY        = money_q;
    assign CARWASH_I    = carwash_q;
    assign TANKFULL     = tankfull_q;
    assign credit       = credit_q;
    assign volume       = volume_q;
    assign change_valid = change_valid_q;
    assign change       = change_q;

endmodule : pump_console
